// File: rtl/fw_dbus_pipe.sv
// Data-bus pipeline stage between the core data port and data memory: configurable
// request/response delay, valid/ready on both sides, flush of unissued reads, memory watchdog.
module fw_dbus_pipe #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REQ_STAGES = 1,
    parameter int unsigned RSP_STAGES = 1,
    parameter int unsigned TIMEOUT    = 64,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = '1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    s_dvalid,
    input  logic [ADDR_WIDTH-1:0]   s_daddr,
    input  logic [DATA_WIDTH-1:0]   s_dwdata,
    input  logic [DATA_WIDTH/8-1:0] s_dwstb,
    input  logic                    s_dwrite,
    output logic [DATA_WIDTH-1:0]   s_drdata,
    output logic                    s_dready,
    output logic                    s_derr,
    input  logic                    flush,
    output logic                    m_dvalid,
    output logic [ADDR_WIDTH-1:0]   m_daddr,
    output logic [DATA_WIDTH-1:0]   m_dwdata,
    output logic [DATA_WIDTH/8-1:0] m_dwstb,
    output logic                    m_dwrite,
    input  logic [DATA_WIDTH-1:0]   m_drdata,
    input  logic                    m_dready,
    output logic                    busy,
    output logic [7:0]              timeout_cnt,
    output logic [2:0]              dbg_state
);

    // Handshake: the core holds s_dvalid and its fields until the one-cycle s_dready
    // pulse; the memory sees m_dvalid with constant fields until it returns m_dready.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_DLY = 3'd1,
        MEM     = 3'd2,
        RSP_DLY = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [2:0]              dly_q, dly_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstb_q, wstb_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [7:0]              tcnt_q, tcnt_d;

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        wd_d    = wd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstb_d  = wstb_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE: begin
                if (s_dvalid) begin
                    addr_d  = s_daddr;
                    wdata_d = s_dwdata;
                    wstb_d  = s_dwstb;
                    write_d = s_dwrite;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    wd_d    = '0;
                    dly_d   = 3'(REQ_STAGES);
                    state_d = (REQ_STAGES == 0) ? MEM : REQ_DLY;
                end
            end
            REQ_DLY: begin
                // Only reads may be cancelled; a write is already committed by the core.
                if (flush && !write_q) begin
                    state_d = IDLE;
                end else if (dly_q == 3'd1) begin
                    state_d = MEM;
                end else begin
                    dly_d = dly_q - 3'd1;
                end
            end
            MEM: begin
                if (m_dready) begin
                    if (!write_q) rdata_d = m_drdata;
                    dly_d   = 3'(RSP_STAGES);
                    state_d = (RSP_STAGES == 0) ? DONE : RSP_DLY;
                end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                    if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
                    state_d = DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RSP_DLY: begin
                if (dly_q == 3'd1) begin
                    state_d = DONE;
                end else begin
                    dly_d = dly_q - 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            dly_q   <= '0;
            wd_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstb_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstb_q  <= wstb_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign m_dvalid    = (state_q == MEM);
    assign m_daddr     = addr_q;
    assign m_dwdata    = wdata_q;
    assign m_dwstb     = wstb_q;
    assign m_dwrite    = write_q;
    assign s_dready    = (state_q == DONE);
    assign s_derr      = (state_q == DONE) && err_q;
    assign s_drdata    = (state_q == DONE) ? rdata_q : '0;
    assign busy        = (state_q != IDLE);
    assign timeout_cnt = tcnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fw_dbus_pipe.sv
// Directed bench for fw_dbus_pipe: three instances cover delayed stages, flush and
// zero-stage back-to-back traffic.
module tb_fw_dbus_pipe;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: REQ=1, RSP=1, TIMEOUT=4
    logic a_s_dvalid, a_s_dwrite, a_flush, a_mem_en;
    logic [31:0] a_s_daddr, a_s_dwdata, a_m_drdata;
    logic [3:0] a_s_dwstb;
    logic [31:0] a_s_drdata, a_m_daddr, a_m_dwdata;
    logic [3:0] a_m_dwstb;
    logic a_s_dready, a_s_derr, a_m_dvalid, a_m_dwrite, a_m_dready, a_busy;
    logic [7:0] a_tcnt;
    logic [2:0] a_dbg;
    assign a_m_dready = a_m_dvalid & a_mem_en;

    fw_dbus_pipe #(.REQ_STAGES(1), .RSP_STAGES(1), .TIMEOUT(4)) u_a (
        .clock(clock), .reset(rst_n), .s_dvalid(a_s_dvalid), .s_daddr(a_s_daddr),
        .s_dwdata(a_s_dwdata), .s_dwstb(a_s_dwstb), .s_dwrite(a_s_dwrite),
        .s_drdata(a_s_drdata), .s_dready(a_s_dready), .s_derr(a_s_derr), .flush(a_flush),
        .m_dvalid(a_m_dvalid), .m_daddr(a_m_daddr), .m_dwdata(a_m_dwdata),
        .m_dwstb(a_m_dwstb), .m_dwrite(a_m_dwrite), .m_drdata(a_m_drdata),
        .m_dready(a_m_dready), .busy(a_busy), .timeout_cnt(a_tcnt), .dbg_state(a_dbg));

    // Instance B: REQ=3, RSP=1, zero-wait memory
    logic b_s_dvalid, b_s_dwrite, b_flush;
    logic [31:0] b_s_daddr, b_s_dwdata, b_m_drdata;
    logic [3:0] b_s_dwstb;
    logic [31:0] b_s_drdata, b_m_daddr, b_m_dwdata;
    logic [3:0] b_m_dwstb;
    logic b_s_dready, b_s_derr, b_m_dvalid, b_m_dwrite, b_m_dready, b_busy;
    logic [7:0] b_tcnt;
    logic [2:0] b_dbg;
    assign b_m_dready = b_m_dvalid;

    fw_dbus_pipe #(.REQ_STAGES(3), .RSP_STAGES(1)) u_b (
        .clock(clock), .reset(rst_n), .s_dvalid(b_s_dvalid), .s_daddr(b_s_daddr),
        .s_dwdata(b_s_dwdata), .s_dwstb(b_s_dwstb), .s_dwrite(b_s_dwrite),
        .s_drdata(b_s_drdata), .s_dready(b_s_dready), .s_derr(b_s_derr), .flush(b_flush),
        .m_dvalid(b_m_dvalid), .m_daddr(b_m_daddr), .m_dwdata(b_m_dwdata),
        .m_dwstb(b_m_dwstb), .m_dwrite(b_m_dwrite), .m_drdata(b_m_drdata),
        .m_dready(b_m_dready), .busy(b_busy), .timeout_cnt(b_tcnt), .dbg_state(b_dbg));

    // Instance C: REQ=0, RSP=0, bench-driven memory waits
    logic c_s_dvalid, c_s_dwrite, c_flush, c_m_dready;
    logic [31:0] c_s_daddr, c_s_dwdata, c_m_drdata;
    logic [3:0] c_s_dwstb;
    logic [31:0] c_s_drdata, c_m_daddr, c_m_dwdata;
    logic [3:0] c_m_dwstb;
    logic c_s_dready, c_s_derr, c_m_dvalid, c_m_dwrite, c_busy;
    logic [7:0] c_tcnt;
    logic [2:0] c_dbg;

    fw_dbus_pipe #(.REQ_STAGES(0), .RSP_STAGES(0)) u_c (
        .clock(clock), .reset(rst_n), .s_dvalid(c_s_dvalid), .s_daddr(c_s_daddr),
        .s_dwdata(c_s_dwdata), .s_dwstb(c_s_dwstb), .s_dwrite(c_s_dwrite),
        .s_drdata(c_s_drdata), .s_dready(c_s_dready), .s_derr(c_s_derr), .flush(c_flush),
        .m_dvalid(c_m_dvalid), .m_daddr(c_m_daddr), .m_dwdata(c_m_dwdata),
        .m_dwstb(c_m_dwstb), .m_dwrite(c_m_dwrite), .m_drdata(c_m_drdata),
        .m_dready(c_m_dready), .busy(c_busy), .timeout_cnt(c_tcnt), .dbg_state(c_dbg));

    task automatic test_reset();
        a_s_dvalid = 0; a_s_dwrite = 0; a_flush = 0; a_mem_en = 1;
        a_s_daddr = 0; a_s_dwdata = 0; a_s_dwstb = 0; a_m_drdata = 0;
        b_s_dvalid = 0; b_s_dwrite = 0; b_flush = 0;
        b_s_daddr = 0; b_s_dwdata = 0; b_s_dwstb = 0; b_m_drdata = 0;
        c_s_dvalid = 0; c_s_dwrite = 0; c_flush = 0; c_m_dready = 0;
        c_s_daddr = 0; c_s_dwdata = 0; c_s_dwstb = 0; c_m_drdata = 0;
        rst_n = 0;
        repeat (3) @(negedge clock);
        rst_n = 1;
        @(negedge clock);
        n_tests++; if ({a_s_dready, a_s_derr, a_m_dvalid, a_busy} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {a_s_dready, a_s_derr, a_m_dvalid, a_busy}); end
        n_tests++; if (a_tcnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_tcnt: got %0d expected 0", a_tcnt); end
        n_tests++; if ({a_m_daddr, a_m_dwdata, a_s_drdata, a_m_dwstb, a_m_dwrite} !== '0) begin
            n_fail++; $display("FAIL reset_data: addr %h wdata %h rdata %h expected all 0", a_m_daddr, a_m_dwdata, a_s_drdata); end
        n_tests++; if ({a_dbg, b_busy, c_busy, b_m_dvalid, c_m_dvalid} !== 7'b0) begin
            n_fail++; $display("FAIL reset_state: got %b expected 0", {a_dbg, b_busy, c_busy, b_m_dvalid, c_m_dvalid}); end
    endtask

    // Read: m_dvalid only in cycle 2, s_dready in cycle 4.
    task automatic test_read(input logic [31:0] addr, input logic [31:0] data, input string nm);
        a_mem_en = 1; a_m_drdata = data;
        a_s_daddr = addr; a_s_dwrite = 0; a_s_dwstb = 4'hF; a_s_dvalid = 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            n_tests++; if (a_m_dvalid !== (k == 2)) begin
                n_fail++; $display("FAIL %s_mvalid cycle %0d: got %b expected %b", nm, k, a_m_dvalid, (k == 2)); end
            if (k == 2) begin
                n_tests++; if (a_m_daddr !== addr || a_m_dwrite !== 1'b0) begin
                    n_fail++; $display("FAIL %s_maddr: got %h/%b expected %h/0", nm, a_m_daddr, a_m_dwrite, addr); end
            end
            n_tests++; if (a_s_dready !== (k == 4)) begin
                n_fail++; $display("FAIL %s_sready cycle %0d: got %b expected %b", nm, k, a_s_dready, (k == 4)); end
            if (k == 4) begin
                n_tests++; if (a_s_drdata !== data || a_s_derr !== 1'b0) begin
                    n_fail++; $display("FAIL %s_rdata: got %h err %b expected %h err 0", nm, a_s_drdata, a_s_derr, data); end
            end
            if (a_s_dready) a_s_dvalid = 0;
        end
    endtask

    task automatic test_write();
        int mv = 0;
        int rd = 0;
        a_mem_en = 1; a_m_drdata = 32'h1111_2222;
        a_s_daddr = 32'h200; a_s_dwdata = 32'hA5A5_A5A5; a_s_dwstb = 4'b0011;
        a_s_dwrite = 1; a_s_dvalid = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (a_m_dvalid) begin
                mv++;
                n_tests++; if (a_m_dwstb !== 4'b0011 || a_m_dwdata !== 32'hA5A5_A5A5 ||
                               a_m_daddr !== 32'h200 || a_m_dwrite !== 1'b1) begin
                    n_fail++; $display("FAIL write_mfields: stb %b data %h addr %h wr %b expected 0011 a5a5a5a5 200 1",
                                       a_m_dwstb, a_m_dwdata, a_m_daddr, a_m_dwrite); end
            end
            if (a_s_dready) begin
                rd++;
                n_tests++; if (a_s_drdata !== 32'h0 || a_s_derr !== 1'b0) begin
                    n_fail++; $display("FAIL write_rdata: got %h err %b expected 0 err 0", a_s_drdata, a_s_derr); end
                a_s_dvalid = 0;
            end
        end
        n_tests++; if (mv != 1 || rd != 1) begin
            n_fail++; $display("FAIL write_counts: mvalid %0d ready %0d expected 1 1", mv, rd); end
    endtask

    // Flush driven during the second REQ_DLY cycle (cycle 2).
    task automatic test_flush(input logic is_write);
        int mv = 0;
        int rd_k = 0;
        int rd = 0;
        b_s_daddr = 32'h440; b_s_dwdata = 32'h0BAD_F00D; b_s_dwstb = 4'hF;
        b_m_drdata = 32'h7777_7777; b_s_dwrite = is_write; b_s_dvalid = 1;
        @(negedge clock);
        @(negedge clock);
        b_flush = 1;
        if (!is_write) b_s_dvalid = 0;
        for (int k = 3; k <= 14; k++) begin
            @(negedge clock);
            b_flush = 0;
            if (k == 3 && !is_write) begin
                n_tests++; if (b_busy !== 1'b0) begin
                    n_fail++; $display("FAIL flush_rd_busy: got %b expected 0", b_busy); end
            end
            if (b_m_dvalid) mv++;
            if (b_s_dready) begin
                rd++;
                if (rd_k == 0) rd_k = k;
                b_s_dvalid = 0;
            end
        end
        if (is_write) begin
            n_tests++; if (mv != 1 || rd != 1 || rd_k != 6) begin
                n_fail++; $display("FAIL flush_wr_done: mvalid %0d ready %0d at cycle %0d expected 1 1 at 6", mv, rd, rd_k); end
        end else begin
            n_tests++; if (mv != 0 || rd != 0) begin
                n_fail++; $display("FAIL flush_rd_cancel: mvalid %0d ready %0d expected 0 0", mv, rd); end
        end
    endtask

    task automatic test_timeout();
        int mv = 0;
        int rd_k = 0;
        a_mem_en = 0; a_s_daddr = 32'h500; a_s_dwrite = 0; a_s_dvalid = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (a_m_dvalid) mv++;
            if (a_s_dready && rd_k == 0) begin
                rd_k = k;
                n_tests++; if (a_s_derr !== 1'b1 || a_s_drdata !== 32'hFFFF_FFFF) begin
                    n_fail++; $display("FAIL timeout_rsp: err %b data %h expected 1 ffffffff", a_s_derr, a_s_drdata); end
                a_s_dvalid = 0;
            end
        end
        n_tests++; if (rd_k != 6 || mv != 4) begin
            n_fail++; $display("FAIL timeout_timing: ready cycle %0d mvalid %0d expected 6 4", rd_k, mv); end
        n_tests++; if (a_tcnt !== 8'd1) begin
            n_fail++; $display("FAIL timeout_cnt1: got %0d expected 1", a_tcnt); end
    endtask

    task automatic test_timeout_saturate();
        int pulses = 1;
        int cyc = 0;
        a_mem_en = 0; a_s_dvalid = 1;
        while (pulses < 300 && cyc < 3000) begin
            @(negedge clock);
            cyc++;
            if (a_s_dready) begin
                pulses++;
                if (pulses == 200) begin
                    n_tests++; if (a_tcnt !== 8'd200) begin
                        n_fail++; $display("FAIL timeout_cnt200: got %0d expected 200", a_tcnt); end
                end
                if (pulses == 300) a_s_dvalid = 0;
            end
        end
        a_s_dvalid = 0;
        @(negedge clock);
        n_tests++; if (pulses != 300) begin
            n_fail++; $display("FAIL timeout_bulk: got %0d timeouts expected 300", pulses); end
        n_tests++; if (a_tcnt !== 8'd255) begin
            n_fail++; $display("FAIL timeout_sat: got %0d expected 255", a_tcnt); end
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        a_mem_en = 0; a_s_daddr = 32'h600; a_s_dwrite = 0; a_s_dvalid = 1;
        for (int k = 1; k <= 10 && seen == 0; k++) begin
            @(negedge clock);
            if (a_m_dvalid) seen = 1;
        end
        n_tests++; if (seen != 1) begin
            n_fail++; $display("FAIL midrst_reach_mem: got %0d expected 1", seen); end
        rst_n = 0; a_s_dvalid = 0;
        @(negedge clock);
        n_tests++; if ({a_m_dvalid, a_busy, a_s_dready} !== 3'b0 || a_tcnt !== 8'd0 || a_m_daddr !== 32'h0) begin
            n_fail++; $display("FAIL midrst_state: mv/busy/rdy %b tcnt %0d addr %h expected 000 0 0",
                               {a_m_dvalid, a_busy, a_s_dready}, a_tcnt, a_m_daddr); end
        rst_n = 1;
        @(negedge clock);
        test_read(32'h300, 32'h1234_5678, "midrst_read");
    endtask

    // Zero stages, s_dvalid held high across 10 requests, random memory waits.
    task automatic test_back_to_back();
        int done = 0;
        int entries = 0;
        int extra = 0;
        int wait_left;
        logic prev_mv = 0;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0] e_stb;
        logic e_wr;
        e_addr = 32'h1000; e_wdata = 32'h5A00_0000; e_rdata = 32'hC0DE_0000;
        e_stb = 4'd1; e_wr = 1'b0;
        c_s_daddr = e_addr; c_s_dwdata = e_wdata; c_s_dwstb = e_stb; c_s_dwrite = e_wr;
        c_m_drdata = e_rdata; c_m_dready = 0; c_s_dvalid = 1;
        wait_left = $urandom_range(0, 3);
        for (int cyc = 0; cyc < 400 && done < 10; cyc++) begin
            @(negedge clock);
            c_m_dready = 0;
            if (c_m_dvalid) begin
                if (!prev_mv) entries++;
                n_tests++; if (c_m_daddr !== e_addr || c_m_dwdata !== e_wdata ||
                               c_m_dwstb !== e_stb || c_m_dwrite !== e_wr) begin
                    n_fail++; $display("FAIL b2b_mfields req %0d: %h %h %b %b expected %h %h %b %b", done,
                                       c_m_daddr, c_m_dwdata, c_m_dwstb, c_m_dwrite, e_addr, e_wdata, e_stb, e_wr); end
                if (wait_left == 0) c_m_dready = 1;
                else wait_left--;
            end
            prev_mv = c_m_dvalid;
            if (c_s_dready) begin
                n_tests++; if (c_s_drdata !== (e_wr ? 32'h0 : e_rdata) || c_s_derr !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_rdata req %0d: got %h err %b expected %h err 0", done,
                                       c_s_drdata, c_s_derr, (e_wr ? 32'h0 : e_rdata)); end
                done++;
                if (done < 10) begin
                    e_addr = e_addr + 32'h4; e_wdata = e_wdata + 32'h1; e_rdata = e_rdata + 32'h1;
                    e_stb = e_stb + 4'd1; e_wr = ~e_wr;
                    c_s_daddr = e_addr; c_s_dwdata = e_wdata; c_s_dwstb = e_stb; c_s_dwrite = e_wr;
                    c_m_drdata = e_rdata;
                    wait_left = $urandom_range(0, 3);
                end else begin
                    c_s_dvalid = 0;
                end
            end
        end
        c_s_dvalid = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            c_m_dready = 0;
            if (c_s_dready) extra++;
        end
        n_tests++; if (done != 10 || entries != 10 || extra != 0) begin
            n_fail++; $display("FAIL b2b_counts: ready %0d mem %0d extra %0d expected 10 10 0", done, entries, extra); end
    endtask

    initial begin
        test_reset();
        test_read(32'h100, 32'hDEAD_BEEF, "read");
        test_write();
        test_flush(1'b0);
        test_flush(1'b1);
        test_timeout();
        test_timeout_saturate();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fw_dbus_pipe.md
# fw_dbus_pipe

Parametrised data-bus pipeline stage placed between the fwrisc data port and the data memory. It replaces the fixed one-cycle register slice with a configurable request/response delay, a proper valid/ready handshake on both sides, and byte-strobe forwarding. It adds flush-based cancellation of not-yet-issued reads and a memory-timeout watchdog with an error response. One transaction is in flight at a time.

## Interface
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width; a multiple of 8; strobe width is DATA_WIDTH/8
- REQ_STAGES, 1, request delay cycles before the memory sees the request (0..7)
- RSP_STAGES, 1, response delay cycles after memory ready (0..7)
- TIMEOUT, 64, maximum cycles in MEM before abort; 0 disables the watchdog
- ERR_DATA, all ones, read data returned on timeout

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- s_dvalid  in  1  core request valid; held high until s_dready
- s_daddr  in  ADDR_WIDTH  core address
- s_dwdata  in  DATA_WIDTH  core write data
- s_dwstb  in  DATA_WIDTH/8  core byte strobes
- s_dwrite  in  1  1 = write, 0 = read
- s_drdata  out  DATA_WIDTH  read data, valid while s_dready = 1
- s_dready  out  1  one-cycle completion pulse to the core
- s_derr  out  1  asserted with s_dready when the transaction timed out
- flush  in  1  core pipeline flush
- m_dvalid  out  1  memory request valid
- m_daddr, m_dwdata, m_dwstb, m_dwrite  out  as s_*  captured request fields
- m_drdata  in  DATA_WIDTH  memory read data
- m_dready  in  1  memory completion
- busy  out  1  state != IDLE
- timeout_cnt  out  8  saturating count of timeouts since reset

## Operation
- States: IDLE, REQ_DLY, MEM, RSP_DLY, DONE.
- IDLE: when s_dvalid = 1, capture the address, write data, strobes and the write flag into internal registers. Load the delay counter with REQ_STAGES. Go to REQ_DLY, or to MEM if REQ_STAGES = 0.
- REQ_DLY: decrement the counter each cycle. When the counter reaches 1, go to MEM.
  - flush = 1 on a read: cancel and go to IDLE. No s_dready is issued and the memory is never accessed.
  - flush = 1 on a write: ignored; writes always complete.
- MEM: m_dvalid = 1. m_* outputs drive the captured fields and stay constant for the whole state. The watchdog counter increments each cycle.
  - m_dready = 1: capture m_drdata (reads only). Load the counter with RSP_STAGES. Go to RSP_DLY, or to DONE if RSP_STAGES = 0.
  - Watchdog reaches TIMEOUT with m_dready = 0: set the error flag, load ERR_DATA as read data, increment timeout_cnt (saturates at 255), go to DONE.
  - If m_dready = 1 and the timeout occur in the same cycle, m_dready wins.
  - flush is ignored in MEM and in every later state.
- RSP_DLY: count down RSP_STAGES cycles, then go to DONE.
- DONE: s_dready = 1 for exactly one cycle. s_drdata holds the captured data (0 for writes). s_derr equals the error flag. Go to IDLE.
- The core's s_dvalid may still be high in the DONE cycle. It is not treated as a new request. A new request is accepted in IDLE only.

## Timing
- Reset (reset = 0 at a rising edge): state IDLE; s_dready, s_derr, m_dvalid, busy = 0; all data, address and strobe outputs = 0; timeout_cnt = 0. This applies mid-transaction too: m_dvalid drops after that edge.
- m_dvalid, s_dready and s_derr are decoded from registered state (glitch-free, no combinational path from inputs).
- Latency: s_dvalid seen in cycle 0 → m_dvalid in cycle 1 + REQ_STAGES. With memory ready in cycle m, s_dready is in cycle m + 1 + RSP_STAGES.
- Throughput: at most one transaction per 2 + REQ_STAGES + RSP_STAGES + memory-cycles cycles. The fastest back-to-back case is 3 cycles when both stages are 0 and the memory is zero-wait.

## Test plan
- REQ_STAGES = 1, RSP_STAGES = 1, zero-wait memory. Read of 0x100 with memory returning 0xDEADBEEF → m_dvalid in cycle 2 only; s_dready in cycle 4 with s_drdata = 0xDEADBEEF and s_derr = 0.
- Write 0xA5A5A5A5 to 0x200 with s_dwstb = 4'b0011 → m_dwstb = 4'b0011 and m_dwdata unchanged while m_dvalid is high; one s_dready pulse with s_drdata = 0.
- REQ_STAGES = 3, read with flush = 1 in the second REQ_DLY cycle → m_dvalid never asserts, no s_dready, busy = 0 next cycle. Repeat as a write → the write completes normally.
- TIMEOUT = 4, memory never ready → s_dready with s_derr = 1 and s_drdata = 0xFFFFFFFF; timeout_cnt = 1. After 300 timeouts, timeout_cnt = 255.
- Pulse reset = 0 while in MEM → m_dvalid = 0, busy = 0 next cycle. A following request completes normally.
- REQ_STAGES = RSP_STAGES = 0, s_dvalid held high across 10 requests with random memory waits → each request produces exactly one s_dready, and m_* fields match the request every time.
